// File: rtl/wb_stage_if.sv
// Result bus from the execute stage into writeback: valid/ready handshake plus
// the kind, destination index and the three candidate payloads.
interface wb_stage_if;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_kind;
  logic [4:0]   in_rd;
  logic [20:0]  res_e;
  logic [191:0] res_ve;
  logic [191:0] res_sum;

  modport master (output in_valid, in_kind, in_rd, res_e, res_ve, res_sum,
                  input  in_ready);
  modport slave  (input  in_valid, in_kind, in_rd, res_e, res_ve, res_sum,
                  output in_ready);
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: buffers execute results in a FIFO and drains them to the scalar
// or vector register file. Define WB_FWD_EN to add the fwd_* forwarding outputs.
module wb_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  wb_stage_if.slave   res,
  output logic        sc_we,
  output logic [4:0]  sc_addr,
  output logic [20:0] sc_data,
  output logic        vr_we,
  output logic [4:0]  vr_addr,
  output logic [1:0]  vr_beat,
  output logic [47:0] vr_data,
  output logic        busy
`ifdef WB_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [20:0] fwd_data
`endif
);

  localparam int PW     = $clog2(DEPTH);
  localparam int NBEATS = 4;
  localparam int BEAT_W = 48;

  localparam logic [1:0] K_NONE = 2'b00;
  localparam logic [1:0] K_SC   = 2'b01;
  localparam logic [1:0] K_VALU = 2'b10;
  localparam logic [1:0] K_VSUM = 2'b11;

  typedef struct packed {
    logic [1:0]                         kind;
    logic [4:0]                         rd;
    logic [NBEATS-1:0][BEAT_W-1:0]      data;
  } entry_t;

  typedef enum logic {IDLE, VEC} state_t;

  entry_t        mem [DEPTH];
  entry_t        push_ent, head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          push, pop;

  state_t                        state, state_n;
  logic [1:0]                    beat, beat_n;
  logic [NBEATS-1:0][BEAT_W-1:0] vbuf;
  logic [4:0]                    vrd;
  logic                          vbuf_ld;

  logic        sc_we_n, vr_we_n;
  logic [4:0]  sc_addr_n, vr_addr_n;
  logic [20:0] sc_data_n;
  logic [1:0]  vr_beat_n;
  logic [47:0] vr_data_n;

  assign res.in_ready = (count != (PW+1)'(DEPTH));
  assign push         = res.in_valid && res.in_ready;
  assign head         = mem[rd_ptr];

  // Only the payload selected by the kind is kept; scalars live in beat 0.
  always_comb begin
    push_ent      = '0;
    push_ent.kind = res.in_kind;
    push_ent.rd   = res.in_rd;
    case (res.in_kind)
      K_SC:    push_ent.data[0][20:0] = res.res_e;
      K_VALU:  push_ent.data          = res.res_ve;
      K_VSUM:  push_ent.data          = res.res_sum;
      default: push_ent.data          = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    beat_n    = beat;
    pop       = 1'b0;
    vbuf_ld   = 1'b0;
    sc_we_n   = 1'b0;
    sc_addr_n = '0;
    sc_data_n = '0;
    vr_we_n   = 1'b0;
    vr_addr_n = '0;
    vr_beat_n = '0;
    vr_data_n = '0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop = 1'b1;
          case (head.kind)
            K_SC: begin
              // Register 0 is hardwired; the entry is consumed without a write.
              if (head.rd != '0) begin
                sc_we_n   = 1'b1;
                sc_addr_n = head.rd;
                sc_data_n = head.data[0][20:0];
              end
            end
            K_VALU, K_VSUM: begin
              vbuf_ld   = 1'b1;
              vr_we_n   = 1'b1;
              vr_addr_n = head.rd;
              vr_beat_n = 2'd0;
              vr_data_n = head.data[0];
              beat_n    = 2'd1;
              state_n   = VEC;
            end
            default: ;
          endcase
        end
      end
      VEC: begin
        vr_we_n   = 1'b1;
        vr_addr_n = vrd;
        vr_beat_n = beat;
        vr_data_n = vbuf[beat];
        beat_n    = beat + 2'd1;
        if (beat == 2'd3) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= '0;
      vbuf    <= '0;
      vrd     <= '0;
      sc_we   <= 1'b0;
      sc_addr <= '0;
      sc_data <= '0;
      vr_we   <= 1'b0;
      vr_addr <= '0;
      vr_beat <= '0;
      vr_data <= '0;
    end else begin
      state   <= state_n;
      beat    <= beat_n;
      if (vbuf_ld) begin
        vbuf <= head.data;
        vrd  <= head.rd;
      end
      sc_we   <= sc_we_n;
      sc_addr <= sc_addr_n;
      sc_data <= sc_data_n;
      vr_we   <= vr_we_n;
      vr_addr <= vr_addr_n;
      vr_beat <= vr_beat_n;
      vr_data <= vr_data_n;
    end
  end

  assign busy = (count != '0) || (state == VEC) || sc_we || vr_we;

`ifdef WB_FWD_EN
  // Early copy of the scalar write, valid in the pop cycle.
  assign fwd_valid = pop && (head.kind == K_SC) && (head.rd != '0);
  assign fwd_rd    = fwd_valid ? head.rd : '0;
  assign fwd_data  = fwd_valid ? head.data[0][20:0] : '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage; accepted results are turned into an
// expected write stream by a kind-based model and matched against observed writes.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        sc_we, vr_we, busy;
  logic [4:0]  sc_addr, vr_addr;
  logic [20:0] sc_data;
  logic [1:0]  vr_beat;
  logic [47:0] vr_data;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [20:0] fwd_data;
`endif

  wb_stage_if bus();

  wb_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .res(bus),
    .sc_we(sc_we), .sc_addr(sc_addr), .sc_data(sc_data),
    .vr_we(vr_we), .vr_addr(vr_addr), .vr_beat(vr_beat), .vr_data(vr_data),
    .busy(busy)
`ifdef WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] kind; logic [4:0] rd; logic [20:0] e;
    logic [191:0] ve; logic [191:0] sum; int stamp;
  } acc_t;
  typedef struct packed {
    logic is_vec; logic [4:0] addr; logic [1:0] beat; logic [47:0] data;
  } wr_t;

  acc_t acc_q[$];
  wr_t  obs_q[$];
  int   obs_t[$];
  wr_t  exp_q[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0, viol = 0;
  bit   seen_full = 0;

  always @(posedge clk) cyc++;

  // Sampled mid-cycle: what the next edge will accept, and what the ports show now.
  always @(negedge clk) begin
    if (!rst && bus.in_valid && bus.in_ready)
      acc_q.push_back('{bus.in_kind, bus.in_rd, bus.res_e, bus.res_ve, bus.res_sum, cyc});
    if (!bus.in_ready) seen_full = 1;
    if (sc_we && vr_we) viol++;
    if (!sc_we && (sc_addr != 0 || sc_data != 0)) viol++;
    if (!vr_we && (vr_addr != 0 || vr_beat != 0 || vr_data != 0)) viol++;
    if (sc_we) begin obs_q.push_back('{1'b0, sc_addr, 2'd0, {27'd0, sc_data}}); obs_t.push_back(cyc); end
    if (vr_we) begin obs_q.push_back('{1'b1, vr_addr, vr_beat, vr_data}); obs_t.push_back(cyc); end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1);
  end

  function automatic logic [191:0] rand192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: each accepted result becomes 0, 1 or 4 register-file writes, in order.
  function automatic void build_exp();
    logic [191:0] p;
    exp_q.delete();
    foreach (acc_q[i]) begin
      if (acc_q[i].kind == 2'b01 && acc_q[i].rd != 0)
        exp_q.push_back('{1'b0, acc_q[i].rd, 2'd0, {27'd0, acc_q[i].e}});
      else if (acc_q[i].kind[1]) begin
        p = (acc_q[i].kind == 2'b10) ? acc_q[i].ve : acc_q[i].sum;
        for (int b = 0; b < 4; b++)
          exp_q.push_back('{1'b1, acc_q[i].rd, 2'(b), p[48*b +: 48]});
      end
    end
  endfunction

  task automatic clear_logs();
    acc_q.delete(); obs_q.delete(); obs_t.delete(); seen_full = 0;
  endtask

  task automatic push(input logic [1:0] k, input logic [4:0] rd, input logic [20:0] e,
                      input logic [191:0] ve, input logic [191:0] sum);
    int n = 0;
    bus.in_kind = k; bus.in_rd = rd; bus.res_e = e; bus.res_ve = ve; bus.res_sum = sum;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) begin
      miscompares++;
      $display("FAIL push_timeout: in_ready got 0 for 50 cycles, need 1");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin @(posedge clk); #1; n++; end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_timeout: busy got %b after 200 cycles, need 0", busy);
    end
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus.in_ready, busy, sc_we, vr_we} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_flags: {in_ready,busy,sc_we,vr_we} got %b need 1000",
               {bus.in_ready, busy, sc_we, vr_we});
    end
    vectors++;
    if ({sc_addr, sc_data, vr_addr, vr_beat, vr_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: addr/data/beat got %h need 0",
               {sc_addr, sc_data, vr_addr, vr_beat, vr_data});
    end
  endtask

  task automatic test_scalar();
    clear_logs();
    push(2'b01, 5'd5, 21'h1ABCD, rand192(), rand192());
    vectors++;
    if (sc_we !== 1'b0) begin
      miscompares++; $display("FAIL scalar_early: sc_we got %b need 0", sc_we);
    end
    @(posedge clk); #1;
    vectors++;
    if ({sc_we, sc_addr, sc_data, vr_we} !== {1'b1, 5'd5, 21'h1ABCD, 1'b0}) begin
      miscompares++;
      $display("FAIL scalar_write: we/addr/data/vr_we got %b/%0d/%h/%b need 1/5/1abcd/0",
               sc_we, sc_addr, sc_data, vr_we);
    end
    @(posedge clk); #1;
    vectors++;
    if ({sc_we, busy} !== 2'b00) begin
      miscompares++; $display("FAIL scalar_after: sc_we/busy got %b/%b need 0/0", sc_we, busy);
    end
  endtask

  task automatic test_vector();
    logic [191:0] s;
    logic [47:0]  ed;
    for (int i = 0; i < 8; i++) s[24*i +: 24] = 24'(32'h100 + i);
    clear_logs();
    push(2'b11, 5'd3, 21'd0, rand192(), s);
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      ed = {24'(32'h100 + 2*b + 1), 24'(32'h100 + 2*b)};
      vectors++;
      if ({vr_we, vr_addr, vr_beat, vr_data, sc_we} !== {1'b1, 5'd3, 2'(b), ed, 1'b0}) begin
        miscompares++;
        $display("FAIL vector_beat%0d: we/addr/beat/data got %b/%0d/%0d/%h need 1/3/%0d/%h",
                 b, vr_we, vr_addr, vr_beat, vr_data, b, ed);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if ({vr_we, busy} !== 2'b00) begin
      miscompares++; $display("FAIL vector_end: vr_we/busy got %b/%b need 0/0", vr_we, busy);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    push(2'b10, 5'd10, 21'd0, rand192(), rand192());
    push(2'b11, 5'd11, 21'd0, rand192(), rand192());
    push(2'b01, 5'd12, 21'($urandom), rand192(), rand192());
    wait_idle();
    vectors++;
    if (!seen_full || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready: seen_full/in_ready got %b/%b need 1/1", seen_full, bus.in_ready);
    end
    build_exp();
    vectors++;
    if (obs_q.size() != 9 || exp_q.size() != 9) begin
      miscompares++;
      $display("FAIL b2b_count: writes got %0d need 9 (model %0d)", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL b2b_write%0d: got %h need %h", i, obs_q[i], exp_q[i]);
        end
      end
      vectors++;
      if (obs_t[0] != acc_q[0].stamp + 2) begin
        miscompares++;
        $display("FAIL b2b_latency: first beat cycle got %0d need %0d", obs_t[0], acc_q[0].stamp + 2);
      end
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (obs_t[i+1] != obs_t[i] + 1) begin
          miscompares++;
          $display("FAIL b2b_bubble%0d: beat cycle got %0d need %0d", i, obs_t[i+1], obs_t[i] + 1);
        end
      end
    end
  endtask

  task automatic test_suppress();
    clear_logs();
    push(2'b01, 5'd0, 21'h1FFFF, rand192(), rand192());
    push(2'b00, 5'd9, 21'h12345, rand192(), rand192());
    repeat (4) @(posedge clk);
    #1;
    vectors++;
    if (obs_q.size() != 0 || acc_q.size() != 2) begin
      miscompares++;
      $display("FAIL suppress_writes: writes/accepts got %0d/%0d need 0/2", obs_q.size(), acc_q.size());
    end
    vectors++;
    if ({bus.in_ready, busy, seen_full} !== 3'b100) begin
      miscompares++;
      $display("FAIL suppress_state: in_ready/busy/full got %b need 100", {bus.in_ready, busy, seen_full});
    end
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    clear_logs();
    push(2'b10, 5'd12, 21'd0, rand192(), rand192());
    push(2'b11, 5'd13, 21'd0, rand192(), rand192());
    @(negedge clk);
    while (!(vr_we === 1'b1 && vr_beat === 2'd1) && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (n == 20) begin
      miscompares++; $display("FAIL rstmid_beat1: beat 1 got none in 20 cycles, need one");
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({sc_we, vr_we, busy, bus.in_ready, vr_addr, vr_beat, vr_data} !== {4'b0001, 55'd0}) begin
      miscompares++;
      $display("FAIL rstmid_async: sc_we/vr_we/busy/in_ready got %b, beat/data %0d/%h need 0001, 0/0",
               {sc_we, vr_we, busy, bus.in_ready}, vr_beat, vr_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (obs_q.size() != 0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_after: writes/busy/in_ready got %0d/%b/%b need 0/0/1",
               obs_q.size(), busy, bus.in_ready);
    end
  endtask

`ifdef WB_FWD_EN
  task automatic test_forward();
    clear_logs();
    push(2'b01, 5'd7, 21'h00055, rand192(), rand192());
    vectors++;
    if ({fwd_valid, fwd_rd, fwd_data, sc_we} !== {1'b1, 5'd7, 21'h00055, 1'b0}) begin
      miscompares++;
      $display("FAIL fwd_early: valid/rd/data/sc_we got %b/%0d/%h/%b need 1/7/00055/0",
               fwd_valid, fwd_rd, fwd_data, sc_we);
    end
    @(posedge clk); #1;
    vectors++;
    if ({fwd_valid, sc_we, sc_addr, sc_data} !== {1'b0, 1'b1, 5'd7, 21'h00055}) begin
      miscompares++;
      $display("FAIL fwd_write: fwd_valid/sc_we got %b/%b need 0/1", fwd_valid, sc_we);
    end
  endtask
`endif

  task automatic test_random();
    clear_logs();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_kind  = 2'($urandom);
      bus.in_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.res_e    = 21'($urandom);
      bus.res_ve   = rand192();
      bus.res_sum  = rand192();
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    wait_idle();
    build_exp();
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_count: writes got %0d need %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++; $display("FAIL rand_write%0d: got %h need %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    vectors++;
    if (viol != 0) begin
      miscompares++;
      $display("FAIL port_rules: idle-nonzero or dual-write cycles got %0d need 0", viol);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_rd = '0;
    bus.res_e = '0; bus.res_ve = '0; bus.res_sum = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_scalar();
    test_vector();
    test_back_to_back();
    test_suppress();
`ifdef WB_FWD_EN
    test_forward();
`endif
    test_random();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage for the vector processor: the consumer end of the execute stage's result interface. Accepts scalar (21-bit), vector-ALU (192-bit) and vector-sum (192-bit) results through a valid/ready handshake and buffers them in a small FIFO. Drains them into the scalar register file in one beat, or into the vector register file as four 48-bit beats of two 24-bit elements each. Sits between the execute stage and the two register-file write ports.

## Interface
- DEPTH, 2: result FIFO entries (power of two, ≥2).
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  execute stage presents a result.
- in_ready  output  1  FIFO can accept; transfer on in_valid && in_ready at rising edge.
- in_kind  input  2  00 = none, 01 = scalar, 10 = vector ALU, 11 = vector sum.
- in_rd  input  5  destination register index.
- res_e  input  21  scalar result.
- res_ve  input  192  vector ALU result.
- res_sum  input  192  vector adder result.
- sc_we  output  1  scalar register file write enable.
- sc_addr  output  5  scalar write index.
- sc_data  output  21  scalar write data.
- vr_we  output  1  vector register file write enable.
- vr_addr  output  5  vector write index.
- vr_beat  output  2  element-pair index (0..3).
- vr_data  output  48  element pair: {elem[2b+1], elem[2b]}, 24 bits each.
- busy  output  1  FIFO non-empty or vector drain in progress.

## Operation
- On push, store in_kind, in_rd and the selected payload: res_e for kind 01, res_ve for kind 10, res_sum for kind 11. Unselected payloads are ignored.
- in_ready = (count != DEPTH), from registered count.
- When full, no push occurs, even if a pop happens in the same cycle.
- FSM states:
  - IDLE
    - If the FIFO is non-empty, pop the head.
    - Kind 01: drive a one-cycle scalar write, stay in IDLE.
    - Kind 00: drop the entry, no write, stay in IDLE.
    - Kind 10/11: latch the 192-bit payload and rd, emit beat 0, go to VEC.
  - VEC
    - Emit beats 1, 2, 3 on consecutive cycles; no pop occurs during VEC.
    - After beat 3, return to IDLE.
- Beat b carries payload bits [48b+47:48b].
- Scalar write to index 0 is suppressed: sc_we stays 0, the entry is still consumed. Vector index 0 is written normally.
- All write-port outputs are registered. When no write is active: sc_we = vr_we = 0 and sc_addr/sc_data/vr_addr/vr_beat/vr_data = 0.
- Scalar and vector ports are never active in the same cycle.

## Timing
- Reset values: in_ready=1, busy=0, sc_we=0, vr_we=0, all address/data/beat outputs 0. FIFO empty, FSM in IDLE.
- Reset asserted mid-drain: the drain aborts immediately (asynchronous) and FIFO contents are discarded. No further beats issue after rst deasserts.
- Scalar latency: accepted at edge N into an empty, idle stage → sc_we high during cycle N..N+1, i.e. visible after edge N+1.
- Vector latency: accepted at edge N → vr_we high for exactly 4 consecutive cycles starting after edge N+1, with vr_beat 0,1,2,3.
- Sustained throughput: one scalar per cycle; one vector per 4 cycles.
- Back-to-back vectors issue with no bubble: beat 0 of the next vector follows beat 3 of the previous one.
- Push and pop in the same cycle when not full: count unchanged.
- Pointer wrap-around at DEPTH uses log2(DEPTH)-bit pointers.
- busy falls the cycle after the last write beat when the FIFO is empty.

## Configuration
- WB_FWD_EN defined: adds outputs fwd_valid (1), fwd_rd (5), fwd_data (21).
  - These mirror sc_we/sc_addr/sc_data combinationally from the FIFO head in the pop cycle, one cycle before the registered write.
  - The execute stage uses them for forwarding.
  - fwd_valid = 0 for suppressed index-0 writes and for all vector or none entries.
- WB_FWD_EN undefined: those ports do not exist; behaviour is otherwise identical.

## Test plan
- Reset, then push scalar kind 01, rd=5, res_e=21'h1ABCD → one cycle later sc_we=1, sc_addr=5, sc_data=21'h1ABCD; vr_we stays 0; busy returns to 0.
- Push vector kind 11, rd=3, res_sum with element i = 24'h000100+i → vr_we for 4 cycles, vr_addr=3. Beats carry {0x000101,0x000100}, {0x000103,0x000102}, {0x000105,0x000104}, {0x000107,0x000106}.
- Push two vectors (kind 10, then 11) followed by a scalar, with in_valid held → in_ready drops after 2 entries. 8 contiguous vector beats, then one scalar write; in_ready returns to 1 once the FIFO drains.
- Push scalar with rd=0 and kind 00 entries → sc_we and vr_we never assert; both entries consumed, in_ready stays 1.
- Assert rst during vector beat 1 with one entry queued → all outputs 0 immediately; after release no write occurs, busy=0, in_ready=1.
- With WB_FWD_EN: scalar rd=7, data 21'h00055 → fwd_valid=1, fwd_rd=7, fwd_data=21'h00055 in the cycle before sc_we=1.
